// File: rtl/gpu_pkg.sv
// Shared core types: FSM states, PC operations and flag width.
// Imported by every per-thread execution unit.
package gpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        REQUEST,
        WAIT,
        EXECUTE,
        UPDATE,
        DONE
    } core_state_t;

    typedef enum logic [1:0] {
        PC_SEQ,
        PC_BRANCH,
        PC_CALL,
        PC_RET
    } pc_op_t;

    localparam int NZP_WIDTH = 3;

endpackage

// File: rtl/return_stack.sv
// Small hardware LIFO of return addresses.
// Push when full and pop when empty are silently ignored.
module return_stack
    import gpu_pkg::*;
#(
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 4,
    localparam int LW = $clog2(STACK_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic [PC_WIDTH-1:0] wdata,
    output logic [PC_WIDTH-1:0] rdata,
    output logic [LW-1:0]       level,
    output logic                full,
    output logic                empty
);

    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_WIDTH-1:0] mem_q [STACK_DEPTH];
    logic [LW-1:0]       level_q, level_d;
    logic [LW-1:0]       level_m1;
    logic [IW-1:0]       wr_idx, rd_idx;
    logic                do_push, do_pop;

    assign full     = (level_q == LW'(STACK_DEPTH));
    assign empty    = (level_q == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign level_m1 = level_q - LW'(1);
    assign wr_idx   = IW'(level_q);
    assign rd_idx   = IW'(level_m1);
    assign rdata    = mem_q[rd_idx];
    assign level    = level_q;

    // Next occupancy from the guarded push/pop requests
    always_comb begin
        level_d = level_q;
        if (do_push) begin
            level_d = level_q + LW'(1);
        end else if (do_pop) begin
            level_d = level_m1;
        end
    end

    // Entry storage; contents are meaningless until written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= wdata;
        end
    end

    // Occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Per-thread flag latch, branch/call/return resolver and next-PC register.
// Acts only on the first clock edge of each EXECUTE or UPDATE residency.
module pc_branch_unit
    import gpu_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 4,
    localparam int LW = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  core_state_t           core_state,
    input  logic [PC_WIDTH-1:0]   current_pc,
    input  logic [PC_WIDTH-1:0]   decoded_immediate,
    input  logic [NZP_WIDTH-1:0]  decoded_nzp,
    input  logic                  decoded_nzp_we,
    input  pc_op_t                decoded_pc_op,
    input  logic [DATA_WIDTH-1:0] alu_out,
    output logic [PC_WIDTH-1:0]   next_pc,
    output logic [NZP_WIDTH-1:0]  nzp,
    output logic [LW-1:0]         stack_level,
    output logic                  stack_fault
);

    core_state_t          prev_state_q;
    logic [PC_WIDTH-1:0]  next_pc_q, next_pc_d;
    logic [NZP_WIDTH-1:0] nzp_q, nzp_d;
    logic                 fault_q, fault_d;
    logic [PC_WIDTH-1:0]  pc_inc;
    logic [PC_WIDTH-1:0]  ret_addr;
    logic                 push, pop, full, empty;
    logic                 fire_exec, fire_upd;
    logic                 unused_alu;

    assign unused_alu = ^alu_out;
    assign pc_inc     = current_pc + PC_WIDTH'(1);
    assign fire_exec  = enable && (core_state == EXECUTE)
                     && (prev_state_q != EXECUTE);
    assign fire_upd   = enable && (core_state == UPDATE)
                     && (prev_state_q != UPDATE);

    return_stack #(
        .PC_WIDTH   (PC_WIDTH),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .wdata(pc_inc),
        .rdata(ret_addr),
        .level(stack_level),
        .full (full),
        .empty(empty)
    );

    // Resolve the PC operation and flag capture for this edge
    always_comb begin
        next_pc_d = next_pc_q;
        nzp_d     = nzp_q;
        fault_d   = fault_q;
        push      = 1'b0;
        pop       = 1'b0;
        if (fire_exec) begin
            unique case (decoded_pc_op)
                PC_SEQ: next_pc_d = pc_inc;
                PC_BRANCH: begin
                    if ((nzp_q & decoded_nzp) != '0) begin
                        next_pc_d = decoded_immediate;
                    end else begin
                        next_pc_d = pc_inc;
                    end
                end
                PC_CALL: begin
                    if (!full) begin
                        push      = 1'b1;
                        next_pc_d = decoded_immediate;
                    end else begin
                        next_pc_d = pc_inc;
                        fault_d   = 1'b1;
                    end
                end
                PC_RET: begin
                    if (!empty) begin
                        pop       = 1'b1;
                        next_pc_d = ret_addr;
                    end else begin
                        next_pc_d = pc_inc;
                        fault_d   = 1'b1;
                    end
                end
            endcase
        end
        if (fire_upd && decoded_nzp_we) begin
            nzp_d = alu_out[NZP_WIDTH-1:0];
        end
    end

    // State registers; everything freezes while the thread is inactive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_state_q <= IDLE;
            next_pc_q    <= '0;
            nzp_q        <= '0;
            fault_q      <= 1'b0;
        end else if (enable) begin
            prev_state_q <= core_state;
            next_pc_q    <= next_pc_d;
            nzp_q        <= nzp_d;
            fault_q      <= fault_d;
        end
    end

    assign next_pc     = next_pc_q;
    assign nzp         = nzp_q;
    assign stack_fault = fault_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit.
// Expected results come from a small behavioural model of flags and stack.
module tb_pc_branch_unit;
    import gpu_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] pc;
        logic [2:0] lvl;
        logic       fault;
        logic [2:0] nzp;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        enable;
    core_state_t core_state;
    logic [7:0]  current_pc;
    logic [7:0]  decoded_immediate;
    logic [2:0]  decoded_nzp;
    logic        decoded_nzp_we;
    pc_op_t      decoded_pc_op;
    logic [7:0]  alu_out;
    logic [7:0]  next_pc;
    logic [2:0]  nzp;
    logic [2:0]  stack_level;
    logic        stack_fault;

    int total = 0;
    int bad   = 0;

    exp_t       sb[$];
    logic [7:0] m_stack[$];
    logic [2:0] m_nzp;
    logic       m_fault;
    logic [7:0] m_pc;

    pc_branch_unit #(
        .DATA_WIDTH (8),
        .PC_WIDTH   (8),
        .STACK_DEPTH(DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .decoded_immediate(decoded_immediate),
        .decoded_nzp      (decoded_nzp),
        .decoded_nzp_we   (decoded_nzp_we),
        .decoded_pc_op    (decoded_pc_op),
        .alu_out          (alu_out),
        .next_pc          (next_pc),
        .nzp              (nzp),
        .stack_level      (stack_level),
        .stack_fault      (stack_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_stack.delete();
        sb.delete();
        m_nzp   = 3'b000;
        m_fault = 1'b0;
        m_pc    = 8'h00;
    endtask

    // Predict one instruction and queue its expected outputs
    task automatic predict(input pc_op_t op, input logic [7:0] pc,
                           input logic [7:0] imm, input logic [2:0] mask,
                           input logic we, input logic [7:0] alu);
        exp_t e;
        logic [7:0] inc;
        inc = pc + 8'd1;
        case (op)
            PC_SEQ:    m_pc = inc;
            PC_BRANCH: m_pc = ((m_nzp & mask) != 3'b000) ? imm : inc;
            PC_CALL: begin
                if (m_stack.size() < DEPTH) begin
                    m_stack.push_back(inc);
                    m_pc = imm;
                end else begin
                    m_fault = 1'b1;
                    m_pc    = inc;
                end
            end
            default: begin
                if (m_stack.size() > 0) begin
                    m_pc = m_stack.pop_back();
                end else begin
                    m_fault = 1'b1;
                    m_pc    = inc;
                end
            end
        endcase
        if (we) m_nzp = alu[2:0];
        e.pc    = m_pc;
        e.lvl   = 3'(m_stack.size());
        e.fault = m_fault;
        e.nzp   = m_nzp;
        sb.push_back(e);
    endtask

    // Walk one instruction through the core states, then check outputs
    task automatic run_instr(input pc_op_t op, input logic [7:0] pc,
                             input logic [7:0] imm, input logic [2:0] mask,
                             input logic we, input logic [7:0] alu,
                             input int n_exec);
        exp_t e;
        decoded_pc_op     = op;
        current_pc        = pc;
        decoded_immediate = imm;
        decoded_nzp       = mask;
        decoded_nzp_we    = we;
        alu_out           = alu;
        core_state = FETCH;
        @(posedge clk); #1;
        core_state = DECODE;
        @(posedge clk); #1;
        core_state = EXECUTE;
        repeat (n_exec) begin
            @(posedge clk); #1;
        end
        core_state = UPDATE;
        @(negedge clk);
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_empty: got no expected entry for pc=%h", pc);
        end else begin
            e = sb.pop_front();
            if (next_pc !== e.pc) begin
                bad++;
                $display("FAIL next_pc: got %h want %h (pc=%h)",
                         next_pc, e.pc, pc);
            end
            total++;
            if (stack_level !== e.lvl) begin
                bad++;
                $display("FAIL level: got %0d want %0d (pc=%h)",
                         stack_level, e.lvl, pc);
            end
            total++;
            if (stack_fault !== e.fault) begin
                bad++;
                $display("FAIL fault: got %b want %b (pc=%h)",
                         stack_fault, e.fault, pc);
            end
            @(posedge clk); #1;
            core_state = IDLE;
            @(negedge clk);
            total++;
            if (nzp !== e.nzp) begin
                bad++;
                $display("FAIL nzp: got %b want %b (pc=%h)", nzp, e.nzp, pc);
            end
        end
        core_state = IDLE;
    endtask

    task automatic issue(input pc_op_t op, input logic [7:0] pc,
                         input logic [7:0] imm, input logic [2:0] mask,
                         input logic we, input logic [7:0] alu,
                         input int n_exec);
        predict(op, pc, imm, mask, we, alu);
        run_instr(op, pc, imm, mask, we, alu, n_exec);
    endtask

    task automatic do_reset();
        core_state = IDLE;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n             = 1'b0;
        enable            = 1'b1;
        core_state        = IDLE;
        current_pc        = 8'h00;
        decoded_immediate = 8'h00;
        decoded_nzp       = 3'b000;
        decoded_nzp_we    = 1'b0;
        decoded_pc_op     = PC_SEQ;
        alu_out           = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({next_pc, nzp, stack_level, stack_fault} !== 15'd0) begin
            bad++;
            $display("FAIL reset_state: got pc=%h nzp=%b lvl=%0d f=%b want 0",
                     next_pc, nzp, stack_level, stack_fault);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_branch();
        issue(PC_SEQ, 8'h00, 8'h00, 3'b000, 1'b1, 8'h01, 1);
        issue(PC_BRANCH, 8'h10, 8'h20, 3'b001, 1'b0, 8'h00, 1);
        issue(PC_BRANCH, 8'h10, 8'h20, 3'b110, 1'b0, 8'h00, 1);
        issue(PC_BRANCH, 8'h10, 8'h20, 3'b000, 1'b0, 8'h00, 1);
        issue(PC_SEQ, 8'h21, 8'h00, 3'b000, 1'b1, 8'hF4, 1);
        issue(PC_BRANCH, 8'h22, 8'h80, 3'b100, 1'b0, 8'h00, 1);
        issue(PC_BRANCH, 8'h23, 8'h80, 3'b011, 1'b0, 8'h00, 1);
    endtask

    task automatic test_call_ret();
        issue(PC_CALL, 8'h05, 8'h40, 3'b000, 1'b0, 8'h00, 1);
        issue(PC_CALL, 8'h42, 8'h60, 3'b000, 1'b0, 8'h00, 1);
        issue(PC_RET,  8'h61, 8'h00, 3'b000, 1'b0, 8'h00, 1);
        issue(PC_RET,  8'h44, 8'h00, 3'b000, 1'b0, 8'h00, 1);
    endtask

    task automatic test_multi_exec();
        issue(PC_CALL, 8'h07, 8'h50, 3'b000, 1'b0, 8'h00, 3);
        issue(PC_RET,  8'h55, 8'h00, 3'b000, 1'b0, 8'h00, 3);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            issue(PC_CALL, 8'(8'h70 + 8'(i)), 8'(8'h90 + 8'(i)),
                  3'b000, 1'b0, 8'h00, 1);
        end
        issue(PC_SEQ, 8'h99, 8'h00, 3'b000, 1'b0, 8'h00, 1);
        do_reset();
        issue(PC_RET, 8'h30, 8'h00, 3'b000, 1'b0, 8'h00, 1);
        issue(PC_SEQ, 8'h31, 8'h00, 3'b000, 1'b0, 8'h00, 1);
    endtask

    task automatic test_hold();
        issue(PC_CALL, 8'h12, 8'h34, 3'b000, 1'b1, 8'h02, 1);
        enable            = 1'b0;
        decoded_pc_op     = PC_CALL;
        current_pc        = 8'h50;
        decoded_immediate = 8'hA0;
        decoded_nzp_we    = 1'b1;
        alu_out           = 8'h04;
        core_state = FETCH;   @(posedge clk); #1;
        core_state = DECODE;  @(posedge clk); #1;
        core_state = EXECUTE; @(posedge clk); #1;
        core_state = UPDATE;  @(posedge clk); #1;
        core_state = IDLE;
        @(negedge clk);
        total++;
        if (next_pc !== m_pc) begin
            bad++;
            $display("FAIL hold_pc: got %h want %h", next_pc, m_pc);
        end
        total++;
        if (stack_level !== 3'(m_stack.size()) || nzp !== m_nzp) begin
            bad++;
            $display("FAIL hold_state: got lvl=%0d nzp=%b want lvl=%0d nzp=%b",
                     stack_level, nzp, m_stack.size(), m_nzp);
        end
        enable = 1'b1;
        issue(PC_RET, 8'h35, 8'h00, 3'b000, 1'b0, 8'h00, 1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue(PC_CALL, 8'h01, 8'h10, 3'b000, 1'b1, 8'h04, 1);
        issue(PC_CALL, 8'h11, 8'h20, 3'b000, 1'b0, 8'h00, 1);
        decoded_pc_op = PC_RET;
        current_pc    = 8'h21;
        core_state = DECODE;  @(posedge clk); #1;
        core_state = EXECUTE; @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({next_pc, nzp, stack_level, stack_fault} !== 15'd0) begin
            bad++;
            $display("FAIL reset_mid: got pc=%h nzp=%b lvl=%0d f=%b want 0",
                     next_pc, nzp, stack_level, stack_fault);
        end
        core_state = IDLE;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        issue(PC_BRANCH, 8'h40, 8'h00, 3'b111, 1'b0, 8'h00, 1);
    endtask

    task automatic test_wrap();
        issue(PC_SEQ, 8'hFF, 8'h00, 3'b000, 1'b0, 8'h00, 1);
        issue(PC_BRANCH, 8'hFF, 8'h33, 3'b000, 1'b0, 8'h00, 1);
    endtask

    initial begin
        test_reset();
        test_branch();
        test_call_ret();
        test_multi_exec();
        test_overflow();
        test_hold();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Per-thread consumer of the ALU compare result. One instance per thread, beside that thread's alu.
- Latches the N/Z/P flags the alu writes into alu_out[2:0].
- Resolves BRnzp, CALL and RET, and produces the thread's next program counter.
- Holds a small hardware return-address stack so the core supports one-level-deep-or-more subroutines without memory traffic.

Parameters:
- DATA_WIDTH, 8, width of alu_out.
- PC_WIDTH, 8, program counter and immediate width.
- STACK_DEPTH, 4, number of return-address entries (must be >= 1).

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  thread active; when low all state holds.
- core_state  input  core_state_t  current core FSM state (gpu_pkg).
- current_pc  input  PC_WIDTH  PC of the instruction in flight.
- decoded_immediate  input  PC_WIDTH  branch/call target.
- decoded_nzp  input  3  branch condition mask {n,z,p}.
- decoded_nzp_we  input  1  instruction is CMP; capture flags.
- decoded_pc_op  input  pc_op_t  PC_SEQ, PC_BRANCH, PC_CALL, PC_RET.
- alu_out  input  DATA_WIDTH  alu result; bits [2:0] are {N,Z,P} for compares.
- next_pc  output  PC_WIDTH  resolved next PC.
- nzp  output  3  current flag register.
- stack_level  output  $clog2(STACK_DEPTH+1)  entries in use.
- stack_fault  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset (async, rst_n=0), effective immediately:
  - next_pc=0, nzp=3'b000, stack_level=0, stack_fault=0.
  - Stack contents are don't-care.
  - The internal first-cycle tracker is cleared.
- enable=0: no register changes; outputs hold.
- First-cycle qualification:
  - Actions fire only on the first clk edge of each EXECUTE or UPDATE residency.
  - A registered prev_state distinguishes the first edge from later ones.
  - A multi-cycle EXECUTE must never double-push or double-pop.
- EXECUTE first edge, by decoded_pc_op (enum encoding makes the cases mutually exclusive):
  - PC_SEQ: next_pc <= current_pc+1.
  - PC_BRANCH: if (nzp & decoded_nzp) != 0, next_pc <= decoded_immediate; else current_pc+1. Mask 000 is never taken.
  - PC_CALL, stack not full: stack[level] <= current_pc+1; level++; next_pc <= decoded_immediate.
  - PC_CALL, stack full: no push; next_pc <= current_pc+1; stack_fault <= 1.
  - PC_RET, level > 0: next_pc <= stack[level-1]; level--.
  - PC_RET, level = 0: next_pc <= current_pc+1; stack_fault <= 1.
- UPDATE first edge:
  - If decoded_nzp_we=1, nzp <= alu_out[2:0], stored raw (no one-hot check).
  - Otherwise nzp holds.
- Latency:
  - next_pc is valid one edge after EXECUTE entry, i.e. during UPDATE, where the scheduler samples it.
  - A CMP's flags are visible to the next instruction's EXECUTE.
- Arithmetic: current_pc+1 wraps modulo 2^PC_WIDTH (0xFF -> 0x00 at width 8).
- stack_fault is sticky until reset.
- Other core_state values (IDLE, FETCH, DECODE, REQUEST, WAIT, DONE): hold.

Decomposition:
- gpu_pkg additions: typedef enum pc_op_t {PC_SEQ, PC_BRANCH, PC_CALL, PC_RET}; constant NZP_WIDTH=3. core_state_t already lives there.
- One sub-module: return_stack.
  - Parameterised LIFO (PC_WIDTH, STACK_DEPTH).
  - push/pop/wdata/rdata/level/full/empty.
  - Internal guards: push when full and pop when empty are ignored.
- pc_branch_unit owns fault, flags and muxing.

Test Plan:
- Reset and hold: rst_n low mid-EXECUTE with level=2 -> next_pc=0, nzp=000, level=0, fault=0 immediately. With enable=0 over a full instruction cycle, no output changes.
- CMP then branch taken:
  - CMP with alu_out=8'h01 (5>3) in UPDATE -> nzp=001.
  - BRp: current_pc=0x10, imm=0x20, mask=001 -> next_pc=0x20.
  - Same with mask=110 -> next_pc=0x11.
- Call/return nesting:
  - CALL at pc=0x05 -> imm 0x40, level=1.
  - CALL at pc=0x42 -> imm 0x60, level=2.
  - RET -> next_pc=0x43; RET -> next_pc=0x06; level=0, fault=0.
- Stack overflow/underflow, STACK_DEPTH=4:
  - 5 CALLs -> fifth gives next_pc=current_pc+1, level=4, fault=1, and fault stays 1.
  - After reset, RET at pc=0x30 -> next_pc=0x31, fault=1.
- Multi-cycle EXECUTE: hold EXECUTE 3 cycles with PC_CALL -> level increments by exactly 1.
- Wrap: PC_SEQ at current_pc=0xFF -> next_pc=0x00.
